// File: rtl/level_sequencer.sv
// Game-flow controller: starts levels, times the play phase from a 1 Hz tick,
// and drives the initiator side of the post-period postSig/levelComplete handshake.
module level_sequencer #(
  parameter int unsigned NUM_LEVELS     = 8,
  parameter int unsigned PLAY_TIME_S    = 30,
  parameter int unsigned POST_TIMEOUT_S = 10
) (
  input  logic       Clk100M,
  input  logic       Reset,
  input  logic       tick1Hz,
  input  logic       startBtn,
  input  logic       playDone,
  input  logic       levelComplete,
  output logic       postSig,
  output logic       playEn,
  output logic [3:0] level,
  output logic [5:0] secLeft,
  output logic       gameWon,
  output logic       errFlag,
  output logic [2:0] state
);

  localparam int unsigned SEC_W = 6;
  localparam int unsigned LVL_W = 4;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PLAY = 3'd1;
  localparam logic [2:0] ST_POST = 3'd2;
  localparam logic [2:0] ST_WIN  = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  localparam logic [SEC_W-1:0] PLAY_LOAD  = SEC_W'(PLAY_TIME_S);
  localparam logic [SEC_W-1:0] POST_LIMIT = SEC_W'(POST_TIMEOUT_S);
  localparam logic [LVL_W-1:0] LAST_LEVEL = LVL_W'(NUM_LEVELS - 1);

  logic [2:0]       state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [SEC_W-1:0] timer_q, timer_d;
  logic             armed_q, armed_d;
  logic             post_q, play_q, won_q, err_q;

  logic [SEC_W-1:0] timer_inc_c;
  logic             accept_c;
  logic             timeout_c;
  logic             play_end_c;

  // State register plus outputs decoded from the next state, so they move with it
  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      sec_q   <= '0;
      timer_q <= '0;
      armed_q <= 1'b0;
      post_q  <= 1'b0;
      play_q  <= 1'b0;
      won_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      sec_q   <= sec_d;
      timer_q <= timer_d;
      armed_q <= armed_d;
      post_q  <= (state_d == ST_POST);
      play_q  <= (state_d == ST_PLAY);
      won_q   <= (state_d == ST_WIN);
      err_q   <= (state_d == ST_ERR);
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    sec_d       = sec_q;
    timer_d     = timer_q;
    armed_d     = armed_q;
    timer_inc_c = timer_q + SEC_W'(1);
    // A response only counts once a low level has been seen in this POST
    accept_c    = armed_q & levelComplete;
    timeout_c   = tick1Hz & (timer_inc_c == POST_LIMIT);
    play_end_c  = playDone | (tick1Hz & (sec_q == SEC_W'(1)));

    case (state_q)
      ST_IDLE: begin
        level_d = '0;
        sec_d   = '0;
        if (startBtn) begin
          state_d = ST_PLAY;
          sec_d   = PLAY_LOAD;
        end
      end

      ST_PLAY: begin
        if (play_end_c) begin
          state_d = ST_POST;
          sec_d   = '0;
          timer_d = '0;
          armed_d = 1'b0;
        end else if (tick1Hz) begin
          sec_d = sec_q - SEC_W'(1);
        end
      end

      ST_POST: begin
        sec_d = '0;
        if (!armed_q && !levelComplete) begin
          armed_d = 1'b1;
        end
        if (tick1Hz) begin
          timer_d = timer_inc_c;
        end
        // Completion takes priority over a coincident timeout
        if (accept_c) begin
          if (level_q == LAST_LEVEL) begin
            state_d = ST_WIN;
          end else begin
            state_d = ST_PLAY;
            level_d = level_q + LVL_W'(1);
            sec_d   = PLAY_LOAD;
          end
        end else if (timeout_c) begin
          state_d = ST_ERR;
        end
      end

      ST_WIN, ST_ERR: begin
        sec_d = '0;
        if (startBtn) begin
          state_d = ST_IDLE;
          level_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        level_d = '0;
        sec_d   = '0;
        timer_d = '0;
        armed_d = 1'b0;
      end
    endcase
  end

  assign state   = state_q;
  assign level   = level_q;
  assign secLeft = sec_q;
  assign postSig = post_q;
  assign playEn  = play_q;
  assign gameWon = won_q;
  assign errFlag = err_q;

endmodule

// File: doc/level_sequencer.md
# level_sequencer

Game-flow controller for the symbol-counter design and the initiator side of the post-period handshake. It starts each level, times the play phase from a 1 Hz tick, and raises `postSig` to launch the post-period display. It then waits for that block's `levelComplete` response and either advances to the next level, declares a win, or flags a timeout error. It sits between the debounced button inputs, the play-phase logic and the post-period/seven-segment block, all in the `Clk100M` domain.

## Interface
- `NUM_LEVELS`, default 8: number of levels. Range 1..16.
- `PLAY_TIME_S`, default 30: play-phase length in seconds. Range 1..63.
- `POST_TIMEOUT_S`, default 10: maximum number of seconds to wait for `levelComplete`. Range 1..63.

- `Clk100M` in 1: system clock. All logic is on the rising edge.
- `Reset` in 1: synchronous reset, active-high.
- `tick1Hz` in 1: one-cycle pulse once per second, synchronous to `Clk100M`.
- `startBtn` in 1: one-cycle pulse, already debounced.
- `playDone` in 1: one-cycle pulse from the play logic meaning the player finished early.
- `levelComplete` in 1: level-sensitive response from the post-period block.
- `postSig` out 1: post-period request, held high for the whole POST state.
- `playEn` out 1: high only in PLAY.
- `level` out 4: current level, zero-based.
- `secLeft` out 6: seconds remaining in PLAY; 0 outside PLAY.
- `gameWon` out 1: high in WIN.
- `errFlag` out 1: high in ERR.
- `state` out 3: IDLE=0, PLAY=1, POST=2, WIN=3, ERR=4.

## Operation
- **Registered outputs.** All outputs are registered. They are decoded from the next state, so each output changes on the same edge as the state transition.
- **Reset values.** On reset: `state`=IDLE, `level`=0, `secLeft`=0, `postSig`=0, `playEn`=0, `gameWon`=0, `errFlag`=0. The internal post timer and the arm flag are cleared.
- **IDLE.**
  - `startBtn` → PLAY.
  - Set `level`=0 and load `secLeft`=`PLAY_TIME_S`.
  - Other inputs are ignored.
- **PLAY.**
  - `tick1Hz` decrements `secLeft`.
  - Go to POST when `playDone`=1, or when `tick1Hz`=1 with `secLeft`=1. Both cases give the same transition and `secLeft` goes to 0.
  - `startBtn` is ignored.
- **POST entry.** Set `postSig`=1 and `playEn`=0. Clear the post timer and the arm flag.
- **POST, arming.** The arm flag sets in the first POST cycle that samples `levelComplete`=0. A stale high `levelComplete` left over from a previous level is never accepted.
- **POST, completion.** When armed and `levelComplete`=1:
  - If `level`=`NUM_LEVELS`-1 → WIN.
  - Otherwise → PLAY with `level`+1 and `secLeft` reloaded.
  - `postSig` drops on that same edge.
- **POST, timeout.**
  - Each `tick1Hz` increments the post timer.
  - When the timer reaches `POST_TIMEOUT_S` → ERR and `postSig` drops.
  - If an accepted `levelComplete` and the timeout occur in the same cycle, `levelComplete` wins.
  - `startBtn` is ignored.
- **WIN.** `gameWon`=1 and `level` is held. `startBtn` → IDLE.
- **ERR.** `errFlag`=1 and `level` is held. `startBtn` → IDLE.
- **Illegal state encodings** (5..7) → IDLE on the next edge.
- **Level width.** `level` never exceeds `NUM_LEVELS`-1, so there is no wrap. With `NUM_LEVELS`=1, the first completion goes directly to WIN.

## Timing
- **Latency.** Every transition takes one cycle from the sampled input to the updated state and outputs.
- **Start.** `startBtn` sampled at edge N → `playEn`=1 and `secLeft`=`PLAY_TIME_S` after edge N.
- **Handshake.**
  - `postSig` rises on the edge that enters POST.
  - Once armed, the earliest accepted `levelComplete` is the second POST cycle.
  - `postSig` falls one edge after an accepted `levelComplete`.
  - The responder must deassert `levelComplete` after `postSig` falls. That deassertion is what lets the next level's POST arm.
- **Reset mid-operation.** `Reset` asserted in any state gives reset values on the next edge. This includes dropping `postSig`.
- **Timeout timing.** ERR is entered on the edge that samples the `POST_TIMEOUT_S`-th `tick1Hz` in POST.

## Test plan
- **Reset:** drive `Reset` for 2 cycles while in POST → all outputs 0, `state`=0 on the following edge.
- **Play timeout:** `PLAY_TIME_S`=3, `startBtn`, then 3 `tick1Hz` pulses → `secLeft` steps 3,2,1, then POST with `postSig`=1 and `secLeft`=0.
- **Early finish and normal handshake:** `playDone` in PLAY → POST. Hold `levelComplete` low 1 cycle, then high → next edge `postSig`=0, `level`=1, `state`=PLAY, `secLeft`=`PLAY_TIME_S`.
- **Stale response:** `levelComplete` already high when POST is entered and held high → no transition. Drop it for 1 cycle, raise it again → accepted.
- **Win:** `NUM_LEVELS`=2, complete two levels → WIN with `gameWon`=1 and `level`=1. `startBtn` → IDLE.
- **Post timeout and tie:**
  - `POST_TIMEOUT_S`=2 with no response → ERR after the 2nd tick in POST, `errFlag`=1, `postSig`=0.
  - Repeat with an armed `levelComplete`=1 in the same cycle as the 2nd tick → PLAY, not ERR.
